// File: rtl/immgen_pkg.sv
// Shared types and opcode constants for the
// pipelined immediate generator.
package immgen_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_Z    = 3'd5,
    IMM_NONE = 3'd7
  } fmt_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

endpackage

// File: rtl/immgen_decode.sv
// Combinational RV32I/RV64I immediate decoder:
// instruction word -> extended immediate, format, illegal flag.
module immgen_decode
  import immgen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            illegal
);

  logic [4:0]  opc;
  logic        ok;
  logic        is_i, is_s, is_b;
  logic        is_u, is_j, is_z;
  logic [31:0] v;

  assign opc  = inst[6:2];
  assign ok   = (inst[1:0] == 2'b11);
  assign is_i = ok && (opc == OPC_LOAD ||
                       opc == OPC_OPIMM ||
                       opc == OPC_JALR);
  assign is_s = ok && (opc == OPC_STORE);
  assign is_b = ok && (opc == OPC_BRANCH);
  assign is_u = ok && (opc == OPC_LUI ||
                       opc == OPC_AUIPC);
  assign is_j = ok && (opc == OPC_JAL);
  assign is_z = ok && (opc == OPC_SYSTEM);

  // Build a 32-bit value, then sign-extend to XLEN.
  always_comb begin
    v       = '0;
    fmt     = IMM_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      is_i: begin
        v   = {{20{inst[31]}}, inst[31:20]};
        fmt = IMM_I;
      end
      is_s: begin
        v   = {{20{inst[31]}}, inst[31:25],
               inst[11:7]};
        fmt = IMM_S;
      end
      is_b: begin
        v   = {{19{inst[31]}}, inst[31], inst[7],
               inst[30:25], inst[11:8], 1'b0};
        fmt = IMM_B;
      end
      is_u: begin
        v   = {inst[31:12], 12'b0};
        fmt = IMM_U;
      end
      is_j: begin
        v   = {{11{inst[31]}}, inst[31],
               inst[19:12], inst[20],
               inst[30:21], 1'b0};
        fmt = IMM_J;
      end
      is_z: begin
        v   = {27'b0, inst[19:15]};
        fmt = IMM_Z;
      end
      default: illegal = 1'b1;
    endcase
    imm = XLEN'($signed(v));
  end

endmodule

// File: rtl/immgen_pipe.sv
// Immediate generator stage with valid/ready handshake
// and optional two-entry skid buffer (SKID=1).
module immgen_pipe
  import immgen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter bit SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_t             fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  localparam ent_t RST_ENT = '{
    imm: '0, fmt: IMM_NONE, ill: 1'b0, tag: '0
  };

  ent_t d, m, s;
  logic m_valid, s_valid;
  logic accept;

  immgen_decode #(.XLEN(XLEN)) u_dec (
    .inst    (in_inst),
    .imm     (d.imm),
    .fmt     (d.fmt),
    .illegal (d.ill)
  );
  assign d.tag = in_tag;

  assign in_ready = SKID ? !s_valid
                         : (!m_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= RST_ENT;
      s       <= RST_ENT;
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (SKID) begin
      if (!m_valid || out_ready) begin
        if (s_valid) begin
          m       <= s;
          s_valid <= 1'b0;
        end else begin
          m_valid <= accept;
          if (accept) m <= d;
        end
      end else if (accept) begin
        // Main is stalled: park the new entry in skid.
        s       <= d;
        s_valid <= 1'b1;
      end
    end else begin
      if (accept) begin
        m       <= d;
        m_valid <= 1'b1;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = m_valid;
  assign out_imm     = m.imm;
  assign out_fmt     = m.fmt;
  assign out_illegal = m.ill;
  assign out_tag     = m.tag;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench: formats, illegal opcodes, skid
// backpressure, XLEN=64, SKID=0 and async reset.
module tb_immgen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // main: XLEN=32, SKID=1
  logic        a_iv, a_ir, a_ov, a_or, a_ill;
  logic [31:0] a_inst, a_itag, a_imm, a_otag;
  logic [2:0]  a_fmt;
  // wide: XLEN=64, SKID=1
  logic        w_iv, w_ir, w_ov, w_or, w_ill;
  logic [31:0] w_inst, w_itag, w_otag;
  logic [63:0] w_imm;
  logic [2:0]  w_fmt;
  // zero-skid: XLEN=32, SKID=0
  logic        z_iv, z_ir, z_ov, z_or, z_ill;
  logic [31:0] z_inst, z_itag, z_imm, z_otag;
  logic [2:0]  z_fmt;

  immgen_pipe #(.XLEN(32), .TAG_W(32), .SKID(1'b1))
  dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_iv), .in_ready(a_ir),
    .in_inst(a_inst), .in_tag(a_itag),
    .out_valid(a_ov), .out_ready(a_or),
    .out_imm(a_imm), .out_fmt(a_fmt),
    .out_illegal(a_ill), .out_tag(a_otag)
  );

  immgen_pipe #(.XLEN(64), .TAG_W(32), .SKID(1'b1))
  dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_iv), .in_ready(w_ir),
    .in_inst(w_inst), .in_tag(w_itag),
    .out_valid(w_ov), .out_ready(w_or),
    .out_imm(w_imm), .out_fmt(w_fmt),
    .out_illegal(w_ill), .out_tag(w_otag)
  );

  immgen_pipe #(.XLEN(32), .TAG_W(32), .SKID(1'b0))
  dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(z_iv), .in_ready(z_ir),
    .in_inst(z_inst), .in_tag(z_itag),
    .out_valid(z_ov), .out_ready(z_or),
    .out_imm(z_imm), .out_fmt(z_fmt),
    .out_illegal(z_ill), .out_tag(z_otag)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, check it one cycle later.
  task automatic send(input string nm,
                      input logic [31:0] inst,
                      input logic [31:0] tg,
                      input logic [31:0] imm,
                      input logic [2:0]  fmt,
                      input logic        ill);
    a_iv = 1'b1;
    a_inst = inst;
    a_itag = tg;
    step();
    chk({nm, "_valid"}, 64'(a_ov), 64'd1);
    chk({nm, "_imm"}, 64'(a_imm), 64'(imm));
    chk({nm, "_fmt"}, 64'(a_fmt), 64'(fmt));
    chk({nm, "_ill"}, 64'(a_ill), 64'(ill));
    chk({nm, "_tag"}, 64'(a_otag), 64'(tg));
  endtask

  initial begin
    a_iv = 1'b1; a_inst = 32'hFFF00093;
    a_itag = 32'h55; a_or = 1'b1;
    w_iv = 1'b0; w_inst = '0;
    w_itag = '0; w_or = 1'b1;
    z_iv = 1'b0; z_inst = '0;
    z_itag = '0; z_or = 1'b1;

    repeat (3) step();
    chk("rst_ov", 64'(a_ov), 64'd0);
    chk("rst_imm", 64'(a_imm), 64'd0);
    chk("rst_fmt", 64'(a_fmt), 64'd7);
    chk("rst_ill", 64'(a_ill), 64'd0);
    chk("rst_tag", 64'(a_otag), 64'd0);
    chk("rst_ir", 64'(a_ir), 64'd1);
    chk("rst_z_ir", 64'(z_ir), 64'd1);
    a_iv = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_ir", 64'(a_ir), 64'd1);
    chk("post_rst_ov", 64'(a_ov), 64'd0);

    send("i", 32'hFFF00093, 1, 32'hFFFFFFFF, 0, 0);
    send("s", 32'hFE112E23, 2, 32'hFFFFFFFC, 1, 0);
    send("b", 32'hFE000CE3, 3, 32'hFFFFFFF8, 2, 0);
    send("u", 32'h123452B7, 4, 32'h12345000, 3, 0);
    send("j", 32'h001000EF, 5, 32'h00000800, 4, 0);
    send("z", 32'h3400F073, 6, 32'h00000001, 5, 0);
    send("auipc", 32'h00001017, 7,
         32'h00001000, 3, 0);
    send("jalr", 32'hFFC08067, 8,
         32'hFFFFFFFC, 0, 0);
    send("ill00", 32'h00000000, 9, 32'h0, 7, 1);
    send("ill6b", 32'h0000006B, 10, 32'h0, 7, 1);
    send("after_ill", 32'h00500093, 11,
         32'h00000005, 0, 0);

    a_iv = 1'b0;
    step();
    chk("drain_ov", 64'(a_ov), 64'd0);

    // Backpressure through the skid buffer
    a_iv = 1'b1; a_inst = 32'h00100093;
    a_itag = 1; a_or = 1'b1;
    step();
    chk("bp1_tag", 64'(a_otag), 64'd1);
    chk("bp1_ir", 64'(a_ir), 64'd1);
    a_itag = 2; a_inst = 32'h00200093;
    a_or = 1'b0;
    step();
    chk("bp2_tag", 64'(a_otag), 64'd1);
    chk("bp2_ir", 64'(a_ir), 64'd0);
    chk("bp2_ov", 64'(a_ov), 64'd1);
    a_itag = 3; a_inst = 32'h00300093;
    step();
    chk("bp3_tag", 64'(a_otag), 64'd1);
    chk("bp3_imm", 64'(a_imm), 64'd1);
    chk("bp3_ir", 64'(a_ir), 64'd0);
    step();
    chk("bp4_tag", 64'(a_otag), 64'd1);
    chk("bp4_ir", 64'(a_ir), 64'd0);
    a_or = 1'b1;
    step();
    chk("bp5_tag", 64'(a_otag), 64'd2);
    chk("bp5_imm", 64'(a_imm), 64'd2);
    chk("bp5_ir", 64'(a_ir), 64'd1);
    step();
    chk("bp6_tag", 64'(a_otag), 64'd3);
    chk("bp6_imm", 64'(a_imm), 64'd3);
    a_itag = 4;
    step();
    chk("bp7_tag", 64'(a_otag), 64'd4);
    a_itag = 5;
    step();
    chk("bp8_tag", 64'(a_otag), 64'd5);
    chk("bp8_ov", 64'(a_ov), 64'd1);
    a_iv = 1'b0;
    step();
    chk("bp9_ov", 64'(a_ov), 64'd0);

    // XLEN=64 sign extension
    w_iv = 1'b1; w_inst = 32'h800002B7;
    w_itag = 32'hA;
    step();
    chk("w_lui", w_imm, 64'hFFFFFFFF80000000);
    chk("w_lui_fmt", 64'(w_fmt), 64'd3);
    w_inst = 32'hFFF00093;
    step();
    chk("w_addi", w_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("w_addi_fmt", 64'(w_fmt), 64'd0);
    w_iv = 1'b0;

    // SKID=0 throughput and stall
    z_iv = 1'b1; z_inst = 32'h00700093;
    z_itag = 10; z_or = 1'b1;
    step();
    chk("z10_ov", 64'(z_ov), 64'd1);
    chk("z10_tag", 64'(z_otag), 64'd10);
    chk("z10_imm", 64'(z_imm), 64'd7);
    chk("z10_ir", 64'(z_ir), 64'd1);
    z_itag = 11;
    step();
    chk("z11_tag", 64'(z_otag), 64'd11);
    z_itag = 12;
    step();
    chk("z12_tag", 64'(z_otag), 64'd12);
    z_itag = 13; z_or = 1'b0;
    step();
    chk("zst_tag", 64'(z_otag), 64'd12);
    chk("zst_ir", 64'(z_ir), 64'd0);
    chk("zst_ov", 64'(z_ov), 64'd1);
    z_or = 1'b1;
    step();
    chk("z13_tag", 64'(z_otag), 64'd13);
    z_iv = 1'b0;
    step();
    chk("z_drain", 64'(z_ov), 64'd0);

    // Fill main to FULL, then async reset
    a_iv = 1'b1; a_itag = 20; a_or = 1'b0;
    step();
    a_itag = 21;
    step();
    chk("full_ir", 64'(a_ir), 64'd0);
    chk("full_ov", 64'(a_ov), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ov", 64'(a_ov), 64'd0);
    chk("async_ir", 64'(a_ir), 64'd1);
    chk("async_fmt", 64'(a_fmt), 64'd7);
    a_iv = 1'b0;
    step();
    rst_n = 1'b1;
    a_or = 1'b1;
    step();
    chk("rel_ov", 64'(a_ov), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
